// File: rtl/calculator_pkg.sv
// Shared widths and controller state encoding for the memory-to-memory 64-bit adder.
package calculator_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_ADD,
    S_WRITE,
    S_END
  } state_e;
endpackage

// File: rtl/controller.sv
// Sequencer: reads operand pairs, adds them, writes sums back; counts busy cycles until S_END.
module controller
  import calculator_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   read_start_addr_i,
  input  logic [ADDR_W-1:0]   read_end_addr_i,
  input  logic [ADDR_W-1:0]   write_start_addr_i,
  input  logic [ADDR_W-1:0]   write_end_addr_i,
  input  logic [2*DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                we_o,
  output logic [2*DATA_W-1:0] wdata_o,
  output logic [ADDR_W-1:0]   w_addr_o
);
  localparam logic [ADDR_W:0]   ONE_X = 1;
  localparam logic [ADDR_W:0]   THREE_X = 3;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W-1:0] TWO_A = 2;

  state_e              state;
  logic [31:0]         cycle_count;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [2*DATA_W-1:0] op_a_q;
  logic [2*DATA_W-1:0] sum_q;
  logic                empty_d;
  logic                last_d;

  // Range checks carry one extra bit so a pair ending at the top address cannot wrap.
  assign empty_d = (({1'b0, read_start_addr_i} + ONE_X) > {1'b0, read_end_addr_i}) ||
                   (write_start_addr_i > write_end_addr_i);
  assign last_d  = (w_addr_q == write_end_addr_i) ||
                   (({1'b0, r_addr_q} + THREE_X) > {1'b0, read_end_addr_i});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cycle_count <= '0;
      r_addr_q    <= '0;
      w_addr_q    <= '0;
      op_a_q      <= '0;
      sum_q       <= '0;
    end else begin
      if (state != S_END) cycle_count <= cycle_count + 32'd1;
      case (state)
        S_IDLE: begin
          r_addr_q <= read_start_addr_i;
          w_addr_q <= write_start_addr_i;
          state    <= empty_d ? S_END : S_READ_A;
        end
        S_READ_A: state <= S_READ_B;
        S_READ_B: begin
          op_a_q <= rdata_i;
          state  <= S_ADD;
        end
        S_ADD: begin
          sum_q <= op_a_q + rdata_i;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (last_d) begin
            state <= S_END;
          end else begin
            r_addr_q <= r_addr_q + TWO_A;
            w_addr_q <= w_addr_q + ONE_A;
            state    <= S_READ_A;
          end
        end
        default: state <= S_END;
      endcase
    end
  end

  // Write enable decodes straight from state so reset drops it without waiting for a clock.
  always_comb begin
    addr_o = r_addr_q;
    we_o   = 1'b0;
    case (state)
      S_READ_B: addr_o = r_addr_q + ONE_A;
      S_WRITE: begin
        addr_o = w_addr_q;
        we_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign wdata_o  = sum_q;
  assign w_addr_o = w_addr_q;
endmodule

// File: rtl/sram_core.sv
// Single-port memory array: synchronous write, registered read (data one cycle after address).
module sram_core #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] memory [0:2**ADDR_W-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wdata_i;
    rdata_q <= memory[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_wrapper.sv
// Team SRAM wrapper; the array lives in memory_mode_inst so tests can preload and inspect it.
module sram_wrapper #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  sram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) memory_mode_inst (
    .clk_i   (clk_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o)
  );
endmodule

// File: rtl/top_lvl.sv
// Calculator top: controller plus two 32-bit SRAM banks forming 64-bit words {sram_B, sram_A}.
module top_lvl
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr
);
  logic [ADDR_W-1:0]   sram_addr;
  logic                sram_we;
  logic [2*DATA_W-1:0] sram_wdata;
  logic [2*DATA_W-1:0] sram_rdata;
  logic [ADDR_W-1:0]   w_addr;

  controller u_ctrl (
    .clk_i              (clk),
    .rst_i              (rst),
    .read_start_addr_i  (read_start_addr),
    .read_end_addr_i    (read_end_addr),
    .write_start_addr_i (write_start_addr),
    .write_end_addr_i   (write_end_addr),
    .rdata_i            (sram_rdata),
    .addr_o             (sram_addr),
    .we_o               (sram_we),
    .wdata_o            (sram_wdata),
    .w_addr_o           (w_addr)
  );

  sram_wrapper #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) sram_A (
    .clk_i   (clk),
    .addr_i  (sram_addr),
    .we_i    (sram_we),
    .wdata_i (sram_wdata[DATA_W-1:0]),
    .rdata_o (sram_rdata[DATA_W-1:0])
  );

  sram_wrapper #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) sram_B (
    .clk_i   (clk),
    .addr_i  (sram_addr),
    .we_i    (sram_we),
    .wdata_i (sram_wdata[2*DATA_W-1:DATA_W]),
    .rdata_o (sram_rdata[2*DATA_W-1:DATA_W])
  );
endmodule

// File: tb/tb_top_lvl.sv
// Bench for top_lvl: table of range cases plus random ranges, checked against a sequential pair-sum model.
module tb_top_lvl;
  import calculator_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  typedef struct {
    int          rs;
    int          re;
    int          ws;
    int          we;
    int          pat;
    int          exp_cycles;
    logic [63:0] exp_word;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] rsa = '0;
  logic [ADDR_W-1:0] rea = '0;
  logic [ADDR_W-1:0] wsa = '0;
  logic [ADDR_W-1:0] wea = '0;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] word [DEPTH];
  logic [63:0] exp_mem [DEPTH];
  vec_t        tbl [6];

  top_lvl dut (
    .clk              (clk),
    .rst              (rst),
    .read_start_addr  (rsa),
    .read_end_addr    (rea),
    .write_start_addr (wsa),
    .write_end_addr   (wea)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_word(input int a);
    return {dut.sram_B.memory_mode_inst.memory[a], dut.sram_A.memory_mode_inst.memory[a]};
  endfunction

  // Result k = word[rs+2k] + word[rs+2k+1], taken in order so overlapping ranges see earlier sums.
  function automatic int model(input int rs, input int re, input int ws, input int we);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = word[i];
    while ((ws + n <= we) && (rs + 2 * n + 1 <= re)) begin
      exp_mem[ws + n] = exp_mem[rs + 2 * n] + exp_mem[rs + 2 * n + 1];
      n++;
    end
    return n;
  endfunction

  task automatic begin_run(input vec_t v);
    @(negedge clk);
    rst = 1'b1;
    rsa = ADDR_W'(v.rs);
    rea = ADDR_W'(v.re);
    wsa = ADDR_W'(v.ws);
    wea = ADDR_W'(v.we);
    for (int i = 0; i < DEPTH; i++) word[i] = {$urandom, $urandom};
    if (v.pat == 1) begin
      word[v.rs] = 64'h0000_0001_FFFF_FFFF;
      word[v.rs + 1] = 64'h1;
    end else if (v.pat == 2) begin
      word[v.rs] = '1;
      word[v.rs + 1] = '1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      dut.sram_A.memory_mode_inst.memory[i] = word[i][31:0];
      dut.sram_B.memory_mode_inst.memory[i] = word[i][63:32];
    end
    repeat (5) @(negedge clk);
    check("rst_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
    check("rst_cycles", 64'(dut.u_ctrl.cycle_count), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (dut.u_ctrl.state == S_END) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout state=%0d required=%0d", tag, dut.u_ctrl.state, S_END);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut_word(i) !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_mem bad_words=%0d addr=%0d actual=%0h required=%0h",
               tag, bad, first, dut_word(first), exp_mem[first]);
    end
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int n;
    int cyc;
    begin_run(v);
    n = model(v.rs, v.re, v.ws, v.we);
    cyc = (v.exp_cycles >= 0) ? v.exp_cycles : 1 + 4 * n;
    wait_end(tag);
    repeat (3) @(negedge clk);
    check({tag, "_cycles"}, 64'(dut.u_ctrl.cycle_count), 64'(cyc));
    check({tag, "_waddr"}, 64'(dut.w_addr), 64'((n > 0) ? v.ws + n - 1 : v.ws));
    check_mem(tag);
    if (v.pat != 0) check({tag, "_word"}, dut_word(v.ws), v.exp_word);
  endtask

  initial begin
    vec_t v;
    int   writes;
    bit   hit;

    tbl[0] = '{0, 255, 384, 511, 0, 513, 64'h0};
    tbl[1] = '{0, 1, 10, 10, 1, 5, 64'h0000_0002_0000_0000};
    tbl[2] = '{0, 1, 10, 10, 2, 5, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[3] = '{0, 6, 100, 200, 0, 13, 64'h0};
    tbl[4] = '{0, 255, 300, 301, 0, 9, 64'h0};
    tbl[5] = '{5, 5, 40, 60, 0, 1, 64'h0};

    for (int t = 0; t < 6; t++) run_case(tbl[t], $sformatf("vec%0d", t));

    v = '{0, 9, 20, 19, 0, 1, 64'h0};
    run_case(v, "wr_empty");

    v = '{508, 511, 0, 5, 0, 9, 64'h0};
    run_case(v, "top_edge");

    for (int r = 0; r < 6; r++) begin
      v.rs = $urandom_range(2, 400);
      v.re = v.rs + $urandom_range(0, 80) - 2;
      v.ws = $urandom_range(0, 470);
      v.we = v.ws + $urandom_range(0, 40) - 1;
      v.pat = 0;
      v.exp_cycles = -1;
      v.exp_word = '0;
      run_case(v, $sformatf("rand%0d", r));
    end

    // Reset lands inside the 10th write cycle; that write must not happen and the run restarts cleanly.
    v = tbl[0];
    begin_run(v);
    writes = 0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (dut.u_ctrl.state == S_WRITE) begin
        writes++;
        if (writes == 10) hit = 1'b1;
      end
    end
    check("midrst_reach", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
    check("midrst_cycles", 64'(dut.u_ctrl.cycle_count), 64'd0);
    check("midrst_we", 64'(dut.u_ctrl.we_o), 64'd0);
    check("midrst_waddr", 64'(dut.w_addr), 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_kept", dut_word(384 + 8), word[0 + 16] + word[0 + 17]);
    check("midrst_skip", dut_word(384 + 9), word[384 + 9]);
    rst = 1'b0;
    void'(model(v.rs, v.re, v.ws, v.we));
    wait_end("midrst");
    check("midrst_final_cycles", 64'(dut.u_ctrl.cycle_count), 64'd513);
    check_mem("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
